// File: rtl/mdio_pkg.sv
// Shared MDIO clause-22 definitions: FSM states, frame fields, PHY status bit map.
package mdio_pkg;

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} mdio_state_e;

  localparam logic [1:0] ST       = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam int PRE_BITS  = 32;
  localparam int HDR_BITS  = 14;
  localparam int TA_BITS   = 2;
  localparam int DATA_BITS = 16;

  localparam int SPD_HI = 15;
  localparam int SPD_LO = 14;
  localparam int DUPLEX = 13;
  localparam int LINK   = 10;

  localparam logic [1:0] SPEED_1000 = 2'b10;
  localparam logic [1:0] SPEED_100  = 2'b01;
  localparam logic [1:0] SPEED_10   = 2'b00;
  localparam logic [1:0] SPEED_RSVD = 2'b11;

  // Whole frame MSB first; read TA/data bits are placeholders, the bus is released there.
  function automatic logic [63:0] build_frame(input logic [1:0] op, input logic [4:0] phy,
                                              input logic [4:0] regad, input logic [15:0] wdata);
    logic [1:0] ta;
    ta = (op == OP_WRITE) ? 2'b10 : 2'b11;
    return {32'hFFFF_FFFF, ST, op, phy, regad, ta, wdata};
  endfunction

endpackage

// File: rtl/mdio_frame_engine.sv
// One clause-22 frame per start: MDC divider, frame FSM, TX shift out, RX shift in.
module mdio_frame_engine import mdio_pkg::*; #(
  parameter logic [4:0] PHY_ADDR = 5'h01,
  parameter int         CLK_DIV  = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [4:0]  regad,
  input  logic [15:0] wdata,
  output logic        done,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  mdio_state_e   state;
  logic [DW-1:0] div_cnt;
  logic [5:0]    bit_cnt;
  logic [63:0]   tx;
  logic          rd_op;
  logic          rx_en;
  logic          tick, fall, rise;

  assign tick  = (div_cnt == DW'(CLK_DIV - 1));
  assign fall  = tick & mdc;
  assign rise  = tick & ~mdc;
  assign busy  = (state != IDLE);
  assign done  = (state == DONE) && fall && (bit_cnt == 6'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx      <= '0;
      rd_op   <= 1'b0;
      rx_en   <= 1'b0;
      rdata   <= '0;
      mdc     <= 1'b0;
      mdio_o  <= 1'b1;
      mdio_oe <= 1'b0;
    end else if (state == IDLE) begin
      div_cnt <= '0;
      mdc     <= 1'b0;
      mdio_o  <= 1'b1;
      mdio_oe <= 1'b0;
      rx_en   <= 1'b0;
      if (start) begin
        // Raising MDC here makes the first divider wrap a fall tick that drives bit 0.
        state   <= PRE;
        mdc     <= 1'b1;
        bit_cnt <= 6'(PRE_BITS - 1);
        tx      <= build_frame(op, PHY_ADDR, regad, wdata);
        rd_op   <= (op == OP_READ);
      end
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) mdc <= ~mdc;
      if (rise && rx_en) rdata <= {rdata[14:0], mdio_i};
      if (fall) begin
        if (state == DONE) begin
          // First fall releases the bus, second fall ends the one-period gap.
          mdio_oe <= 1'b0;
          mdio_o  <= 1'b1;
          rx_en   <= 1'b0;
          if (bit_cnt == 6'd0) state <= IDLE;
          else bit_cnt <= bit_cnt - 1'b1;
        end else begin
          mdio_o  <= tx[63];
          tx      <= {tx[62:0], 1'b0};
          mdio_oe <= !(rd_op && (state == TA || state == DATA));
          rx_en   <= (state == DATA);
          if (bit_cnt != 6'd0) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else begin
            case (state)
              PRE:     begin state <= HDR;  bit_cnt <= 6'(HDR_BITS - 1);  end
              HDR:     begin state <= TA;   bit_cnt <= 6'(TA_BITS - 1);   end
              TA:      begin state <= DATA; bit_cnt <= 6'(DATA_BITS - 1); end
              default: begin state <= DONE; bit_cnt <= 6'd1;              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: rtl/phy_link_manager.sv
// MDIO master: periodic PHY status poll driving bridge speed/duplex/link, plus a host access port.
module phy_link_manager import mdio_pkg::*; #(
  parameter logic [4:0] PHY_ADDR      = 5'h01,
  parameter logic [4:0] STATUS_REG    = 5'h11,
  parameter int         CLK_DIV       = 50,
  parameter int         POLL_INTERVAL = 1_250_000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [4:0]  host_reg,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic [1:0]  speed_selection,
  output logic        duplex_mode,
  output logic        link_up,
  output logic        busy
);

  localparam int PW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;

  logic [PW-1:0] poll_cnt;
  logic          poll_pend, poll_wrap;
  logic          host_go, start, cur_host, cur_read;
  logic          eng_done;
  logic [15:0]   eng_rdata;
  logic [1:0]    op;
  logic [4:0]    regad;
  logic [15:0]   wdata;

  assign poll_wrap = (poll_cnt == PW'(POLL_INTERVAL - 1));
  // The ack cycle still sees the old request level, so the host is not relaunched there.
  assign host_go   = !busy && host_req && !host_ack;
  assign start     = host_go || (!busy && poll_pend);
  assign op        = (host_go && host_we) ? OP_WRITE : OP_READ;
  assign regad     = host_go ? host_reg : STATUS_REG;
  assign wdata     = host_go ? host_wdata : 16'h0000;

  mdio_frame_engine #(.PHY_ADDR(PHY_ADDR), .CLK_DIV(CLK_DIV)) u_engine (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .regad   (regad),
    .wdata   (wdata),
    .done    (eng_done),
    .rdata   (eng_rdata),
    .busy    (busy),
    .mdc     (mdc),
    .mdio_o  (mdio_o),
    .mdio_oe (mdio_oe),
    .mdio_i  (mdio_i)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      poll_cnt        <= '0;
      poll_pend       <= 1'b1;
      cur_host        <= 1'b0;
      cur_read        <= 1'b1;
      host_ack        <= 1'b0;
      host_rdata      <= '0;
      speed_selection <= SPEED_1000;
      duplex_mode     <= 1'b1;
      link_up         <= 1'b0;
    end else begin
      poll_cnt <= poll_wrap ? '0 : poll_cnt + 1'b1;
      host_ack <= 1'b0;
      if (poll_wrap) poll_pend <= 1'b1;
      else if (start && !host_go) poll_pend <= 1'b0;
      if (start) begin
        cur_host <= host_go;
        cur_read <= !(host_go && host_we);
      end
      if (eng_done) begin
        if (cur_host) begin
          host_ack <= 1'b1;
          if (cur_read) host_rdata <= eng_rdata;
        end else begin
          link_up <= eng_rdata[LINK];
          if (eng_rdata[LINK]) begin
            duplex_mode <= eng_rdata[DUPLEX];
            if (eng_rdata[SPD_HI:SPD_LO] != SPEED_RSVD)
              speed_selection <= eng_rdata[SPD_HI:SPD_LO];
          end
        end
      end
    end
  end

endmodule
